uart_mmio: RTL and testbench
============================

// Module: uart_mmio
// PURPOSE
//  Memory-mapped 8N1 UART peripheral on the data bus; decoded as bus slave id 2 next to DataMemory and BCD.
//  Consumes bus MemRead/MemWrite cycles, serialises TX bytes onto uart_tx and deserialises uart_rx into a one-byte RX holding register.
//  Exposes status for software polling; no interrupts.
// PARAMETERS
//  CLKS_PER_BIT  10417           clk cycles per serial bit (100 MHz / 9600 Hz); legal range 4..65535
//  BASE_ADDR     32'h4000_0018   byte address of register 0; registers are word-spaced
// PORTS
//  clk         in   1   system clock; all state updates on its rising edge
//  reset       in   1   synchronous, active-low reset; 0 = reset, sampled on rising edge of clk
//  MemRead     in   1   bus read strobe, already qualified by slave select
//  MemWrite    in   1   bus write strobe, already qualified by slave select
//  Address     in   32  byte address
//  Write_data  in   32  write data
//  Read_data   out  32  read data, combinational
//  uart_rx     in   1   serial input, asynchronous, idle high
//  uart_tx     out  1   serial output, idle high
// BEHAVIOUR
//  Register map (Address[1:0] ignored; any other address: reads 0, writes ignored):
//   BASE+0 TXD  W: Write_data[7:0] queued for TX. R: 0.
//   BASE+4 RXD  R: {24'b0, rx_byte}; a read (MemRead=1) clears rx_valid at the clock edge. W: ignored.
//   BASE+8 STAT R: {27'b0, tx_drop, rx_ferr, rx_ovr, rx_valid, tx_busy}. W: 1 in bits 4..2 clears that bit.
//  Read_data = MemRead ? mux(Address) : 32'b0; no read latency.
//  Reset (reset=0): uart_tx=1; tx_busy=0; rx_valid=0; rx_ovr=0; rx_ferr=0; tx_drop=0; rx_byte=8'h00.
//   Both FSMs return to IDLE.
//   Reset mid-frame aborts the frame: uart_tx goes 1 at the next edge, and the partial RX byte is discarded.
//  TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state lasts CLKS_PER_BIT cycles.
//   TXD write in IDLE: uart_tx=0 starting the next cycle, and tx_busy=1 from the same edge.
//   tx_busy stays 1 through the STOP bit and clears on the edge that returns the FSM to IDLE.
//   TXD write while tx_busy=1: the byte is dropped and tx_drop is set (sticky). The frame in flight is unaffected.
//   Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back writes give no idle gap beyond 1 cycle.
//  RX path: uart_rx passes a 2-flop synchroniser (2-cycle latency), then the FSM.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: a falling level (0) enters START.
//   START: samples at CLKS_PER_BIT/2; if the sample is 1 it is a glitch -> IDLE, no status change.
//   DATA: samples each bit at mid-bit (every CLKS_PER_BIT cycles after the start midpoint), LSB first.
//   STOP: sample at mid-bit.
//    If 1: rx_byte <= shift reg, rx_valid <= 1. If rx_valid was already 1, set rx_ovr and overwrite rx_byte.
//    If 0: set rx_ferr, discard the byte, and return to IDLE only after the line reads 1.
//   Returns to IDLE at the stop-bit midpoint, so the next start edge can be detected half a bit early.
//  Simultaneous events:
//   RXD read in the same cycle as an RX byte completes: new byte loaded, rx_valid stays 1, rx_ovr not set.
//    The read returns the old byte.
//   STAT write-1-clear in the same cycle as a set event for that bit: the set wins.
//   MemRead and MemWrite both 1: both take effect independently.
//  Counters: bit-timer width = $clog2(CLKS_PER_BIT); bit index is 3 bits and does not wrap past 7.
// STRUCTURE
//  Shared package uart_pkg: register offsets (TXD_OFS=0, RXD_OFS=4, STAT_OFS=8), STAT bit indices,
//   and the FSM state typedef {IDLE, START, DATA, STOP}.
//  Sub-module uart_rx_core: synchroniser plus RX FSM.
//   Outputs a 1-cycle byte_done pulse with data and a 1-cycle frame_err pulse.
//  TX FSM, register file and address decode live in uart_mmio.
// TESTING (bench uses CLKS_PER_BIT=16, BASE_ADDR=32'h4000_0018)
//  1. Reset low 3 cycles then high.
//     -> uart_tx=1; read 0x4000_0020 returns 0; read 0x4000_001C returns 0.
//  2. Write 0x4000_0018=0x000000A5.
//     -> uart_tx waveform 0,1,0,1,0,0,1,0,1,1 (16 cycles each); STAT bit0=1 for 160 cycles, then 0.
//  3. Drive 0x3C 8N1 frame on uart_rx.
//     -> STAT=0x2 after the stop midpoint; read 0x4000_001C returns 0x3C; next STAT read returns 0.
//  4. Send 0x11 then 0x22 without reading.
//     -> RXD=0x22, STAT=0x6; write STAT=0x4 -> STAT=0x2.
//  5. Frame 0x55 with stop bit 0.
//     -> STAT bit3=1, rx_valid=0; a 4-cycle low glitch on idle uart_rx -> no status change.
//  6. Write TXD 0x01, then TXD 0x02 mid-frame; assert reset at cycle 50 of the frame.
//     -> tx_drop=1 before the reset; after reset uart_tx=1 and STAT=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the memory-mapped UART.
//   - register byte offsets relative to BASE_ADDR
//   - bit positions inside the STAT register
//   - serial frame FSM state type, used by both the TX and RX engines
package uart_pkg;

  localparam logic [31:0] TXD_OFS  = 32'h0000_0000;
  localparam logic [31:0] RXD_OFS  = 32'h0000_0004;
  localparam logic [31:0] STAT_OFS = 32'h0000_0008;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_VALID = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;
  localparam int STAT_DROP  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver.
//   A 2-flop synchroniser feeds the frame FSM. The start bit is confirmed at
//   its midpoint, data bits are sampled one bit period apart (LSB first),
//   and the stop bit is sampled at its midpoint.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-low reset
//   i_rx         in   asynchronous serial input, idle high
//   o_byte_done  out  1-cycle pulse: a frame with a valid stop bit completed
//   o_data       out  received byte, valid while o_byte_done is high
//   o_frame_err  out  1-cycle pulse: stop bit sampled low
//   o_state      out  current FSM state, for observation
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rx,
  output logic        o_byte_done,
  output logic [7:0]  o_data,
  output logic        o_frame_err,
  output uart_state_e o_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_sync;
  uart_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_wait_high;
  logic             r_byte_done;
  logic             r_frame_err;
  logic             w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync      <= 2'b11;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_byte_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            // High at the start midpoint means the low level was a glitch.
            if (w_rx) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          // After a framing error the line must return high before a new
          // start edge is accepted, otherwise a held-low line re-triggers.
          if (r_wait_high) begin
            if (w_rx) begin
              r_wait_high <= 1'b0;
              r_state     <= IDLE;
            end
          end else if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_byte_done <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_wait_high <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The shift register is stable from the stop sample until the next DATA bit.
  assign o_data      = r_shift;
  assign o_byte_done = r_byte_done;
  assign o_frame_err = r_frame_err;
  assign o_state     = r_state;

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART bus slave.
//   BASE+0 TXD  (W) byte to transmit
//   BASE+4 RXD  (R) received byte; a read clears rx_valid
//   BASE+8 STAT (R) {tx_drop, rx_ferr, rx_ovr, rx_valid, tx_busy}
//               (W) write-1-clear for bits 4..2
// Bus handshake: a MemRead/MemWrite strobe high at a rising clk edge is one
// complete transfer; there is no wait state and Read_data is combinational.
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   MemRead, MemWrite    bus strobes, already slave-qualified
//   Address, Write_data  byte address and write data
//   Read_data            read data, zero unless MemRead hits a register
//   uart_rx, uart_tx     serial input / output, both idle high
module uart_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXD_ADDR  = BASE_ADDR + TXD_OFS;
  localparam logic [31:0] RXD_ADDR  = BASE_ADDR + RXD_OFS;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + STAT_OFS;

  // Address decode on word address only
  logic w_txd_sel, w_rxd_sel, w_stat_sel;
  logic w_txd_wr, w_rxd_rd, w_stat_wr;
  assign w_txd_sel  = (Address[31:2] == TXD_ADDR[31:2]);
  assign w_rxd_sel  = (Address[31:2] == RXD_ADDR[31:2]);
  assign w_stat_sel = (Address[31:2] == STAT_ADDR[31:2]);
  assign w_txd_wr   = MemWrite & w_txd_sel;
  assign w_rxd_rd   = MemRead & w_rxd_sel;
  assign w_stat_wr  = MemWrite & w_stat_sel;

  // TX engine
  uart_state_e      r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_idx;
  logic [7:0]       r_tx_shift;
  logic             r_tx;
  logic             w_tx_busy;

  assign w_tx_busy = (r_tx_state != IDLE);
  assign uart_tx   = r_tx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (w_txd_wr) begin
            r_tx_state <= START;
            r_tx_cnt   <= '0;
            r_tx_shift <= Write_data[7:0];
            r_tx       <= 1'b0;
          end
        end
        START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_state <= DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx       <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_state <= IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  // RX engine
  logic        w_byte_done;
  logic [7:0]  w_rx_data;
  logic        w_frame_err;
  uart_state_e w_rx_state;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_rx        (uart_rx),
    .o_byte_done (w_byte_done),
    .o_data      (w_rx_data),
    .o_frame_err (w_frame_err),
    .o_state     (w_rx_state)
  );

  // Status / holding registers. Set events take priority over clears.
  logic [7:0] r_rx_byte;
  logic       r_rx_valid, r_rx_ovr, r_rx_ferr, r_tx_drop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_tx_drop  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_byte  <= w_rx_data;
        r_rx_valid <= 1'b1;
      end else if (w_rxd_rd) begin
        r_rx_valid <= 1'b0;
      end

      // A read landing with the new byte consumes the old one: no overrun.
      if (w_byte_done && r_rx_valid && !w_rxd_rd) begin
        r_rx_ovr <= 1'b1;
      end else if (w_stat_wr && Write_data[STAT_OVR]) begin
        r_rx_ovr <= 1'b0;
      end

      if (w_frame_err) begin
        r_rx_ferr <= 1'b1;
      end else if (w_stat_wr && Write_data[STAT_FERR]) begin
        r_rx_ferr <= 1'b0;
      end

      if (w_txd_wr && w_tx_busy) begin
        r_tx_drop <= 1'b1;
      end else if (w_stat_wr && Write_data[STAT_DROP]) begin
        r_tx_drop <= 1'b0;
      end
    end
  end

  // Read mux
  always_comb begin
    Read_data = 32'h0;
    if (MemRead) begin
      if (w_rxd_sel) begin
        Read_data = {24'h0, r_rx_byte};
      end else if (w_stat_sel) begin
        Read_data = {27'h0, r_tx_drop, r_rx_ferr, r_rx_ovr, r_rx_valid, w_tx_busy};
      end
    end
  end

  // Bits with no function in this register map, plus the observation-only RX state.
  logic w_unused;
  assign w_unused = ^{Address[1:0], Write_data[31:8], w_rx_state};

endmodule

// File: tb/tb_uart_mmio.sv
module tb_uart_mmio;

  localparam int          CPB       = 16;
  localparam logic [31:0] BASE      = 32'h4000_0018;
  localparam logic [31:0] A_TXD     = 32'h4000_0018;
  localparam logic [31:0] A_RXD     = 32'h4000_001C;
  localparam logic [31:0] A_STAT    = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic [31:0] Read_data;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the software-visible state
  logic       m_valid, m_ovr, m_ferr, m_drop;
  logic [7:0] m_byte;
  logic       exp_q[$];

  uart_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Model helpers
  function automatic logic [31:0] exp_stat(input logic busy);
    return {27'h0, m_drop, m_ferr, m_ovr, m_valid, busy};
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_drop = 1'b0; m_byte = 8'h00;
  endfunction

  function automatic void model_rx_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_byte  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endfunction

  function automatic void model_stat_write(input logic [31:0] wd);
    if (wd[2]) m_ovr  = 1'b0;
    if (wd[3]) m_ferr = 1'b0;
    if (wd[4]) m_drop = 1'b0;
  endfunction

  // Expected line levels of one 8N1 frame: start, 8 data LSB first, stop
  function automatic void load_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    exp_q.delete();
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[k]);
  endfunction

  // Driver tasks: each bus transfer spans one rising edge, returns 1ns after it
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    MemRead = 1'b1; Address = a;
    #1 d = Read_data;
    @(posedge clk); #1;
    MemRead = 1'b0; Address = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    MemWrite = 1'b1; Address = a; Write_data = wd;
    @(posedge clk); #1;
    MemWrite = 1'b0; Address = 32'h0; Write_data = 32'h0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      uart_rx = bits[k];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    model_rx_frame(b, stop);
    repeat (6) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (uart_tx !== 1'b1) begin
      n_err++; $display("FAIL reset_tx: got %b want 1", uart_tx);
    end
    reset = 1'b1;
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_stat: got %h want 00000000", d);
    end
    bus_read(A_RXD, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL reset_rxd: got %h want 00000000", d);
    end
  endtask

  task automatic test_tx(input logic [7:0] b);
    logic want;
    load_frame(b);
    bus_write(A_TXD, {$urandom_range(0, 16777215), b});
    MemRead = 1'b1; Address = A_STAT;
    #1;
    for (int i = 0; i < 10 * CPB; i++) begin
      want = exp_q.pop_front();
      n_vec++;
      if (uart_tx !== want) begin
        n_err++; $display("FAIL tx_line byte=%h cycle=%0d: got %b want %b", b, i, uart_tx, want);
      end
      n_vec++;
      if (Read_data !== exp_stat(1'b1)) begin
        n_err++; $display("FAIL tx_busy byte=%h cycle=%0d: got %h want %h", b, i, Read_data, exp_stat(1'b1));
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (uart_tx !== 1'b1 || Read_data !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL tx_end byte=%h: got tx=%b stat=%h want tx=1 stat=%h", b, uart_tx, Read_data, exp_stat(1'b0));
    end
    MemRead = 1'b0; Address = 32'h0;
  endtask

  task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2);
    int  cycles;
    logic want;
    bus_write(A_TXD, {24'h0, b1});
    MemRead = 1'b1; Address = A_STAT;
    #1;
    cycles = 0;
    while (Read_data[0] === 1'b1 && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_vec++;
    if (cycles != 10 * CPB) begin
      n_err++; $display("FAIL b2b_busy_len: got %0d want %0d", cycles, 10 * CPB);
    end
    // Next write issued in the first idle cycle
    MemRead = 1'b0; MemWrite = 1'b1; Address = A_TXD; Write_data = {24'h0, b2};
    @(posedge clk); #1;
    MemWrite = 1'b0;
    MemRead = 1'b1; Address = A_STAT;
    load_frame(b2);
    #1;
    for (int i = 0; i < 10 * CPB; i++) begin
      want = exp_q.pop_front();
      n_vec++;
      if (uart_tx !== want || Read_data !== exp_stat(1'b1)) begin
        n_err++; $display("FAIL b2b_frame2 cycle=%0d: got tx=%b stat=%h want tx=%b stat=%h", i, uart_tx, Read_data, want, exp_stat(1'b1));
      end
      @(posedge clk); #1;
    end
    MemRead = 1'b0; Address = 32'h0;
  endtask

  task automatic test_rx(input logic [7:0] b);
    logic [31:0] d;
    drive_rx(b, 1'b1);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL rx_stat byte=%h: got %h want %h", b, d, exp_stat(1'b0));
    end
    bus_read(A_RXD, d);
    n_vec++;
    if (d !== {24'h0, m_byte}) begin
      n_err++; $display("FAIL rx_data: got %h want %h", d, {24'h0, m_byte});
    end
    m_valid = 1'b0;
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL rx_stat_after_read: got %h want %h", d, exp_stat(1'b0));
    end
  endtask

  task automatic test_overrun(input logic [7:0] b1, input logic [7:0] b2);
    logic [31:0] d;
    logic [31:0] wd;
    drive_rx(b1, 1'b1);
    drive_rx(b2, 1'b1);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL ovr_stat: got %h want %h", d, exp_stat(1'b0));
    end
    // Clear overrun; bits 1..0 are not clearable and must be ignored
    wd = 32'h4 | 32'($urandom_range(0, 3));
    bus_write(A_STAT, wd);
    model_stat_write(wd);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL ovr_clear: got %h want %h", d, exp_stat(1'b0));
    end
    bus_read(A_RXD, d);
    n_vec++;
    if (d !== {24'h0, m_byte}) begin
      n_err++; $display("FAIL ovr_data: got %h want %h", d, {24'h0, m_byte});
    end
    m_valid = 1'b0;
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL ovr_final: got %h want %h", d, exp_stat(1'b0));
    end
  endtask

  task automatic test_ferr_glitch();
    logic [31:0] d;
    logic [31:0] wd;
    drive_rx(8'h55, 1'b0);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL ferr_stat: got %h want %h", d, exp_stat(1'b0));
    end
    // Short low pulse on an idle line must be rejected
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL glitch_stat: got %h want %h", d, exp_stat(1'b0));
    end
    wd = 32'h8 | 32'($urandom_range(0, 3));
    bus_write(A_STAT, wd);
    model_stat_write(wd);
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== exp_stat(1'b0)) begin
      n_err++; $display("FAIL ferr_clear: got %h want %h", d, exp_stat(1'b0));
    end
  endtask

  task automatic test_drop_reset();
    logic [31:0] d;
    // Frame starts at edge E0; bus_write returns at E0+1
    bus_write(A_TXD, 32'h01);
    repeat (20) @(posedge clk);
    #1;
    bus_write(A_TXD, 32'h02);   // lands at E21, frame busy
    m_drop = 1'b1;
    bus_read(A_STAT, d);        // returns at E22+1
    n_vec++;
    if (d !== exp_stat(1'b1)) begin
      n_err++; $display("FAIL drop_stat: got %h want %h", d, exp_stat(1'b1));
    end
    n_vec++;
    if (uart_tx !== 1'b1) begin   // cycle 22: data bit 0 of 0x01
      n_err++; $display("FAIL drop_inflight: got %b want 1", uart_tx);
    end
    repeat (27) @(posedge clk);
    #1;                           // E49+1: data bit 2 of 0x01
    n_vec++;
    if (uart_tx !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_tx: got %b want 0", uart_tx);
    end
    reset = 1'b0;                 // sampled at frame cycle 50
    @(posedge clk); #1;
    model_reset();
    n_vec++;
    if (uart_tx !== 1'b1) begin
      n_err++; $display("FAIL reset_abort_tx: got %b want 1", uart_tx);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus_read(A_STAT, d);
    n_vec++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL post_reset_stat: got %h want 00000000", d);
    end
    for (int i = 0; i < 2 * CPB; i++) begin
      n_vec++;
      if (uart_tx !== 1'b1) begin
        n_err++; $display("FAIL post_reset_idle cycle=%0d: got %b want 1", i, uart_tx);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tx(8'hA5);
    for (int i = 0; i < 2; i++) test_tx(8'($urandom_range(0, 255)));
    test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_rx(8'h3C);
    for (int i = 0; i < 4; i++) test_rx(8'($urandom_range(0, 255)));
    test_overrun(8'h11, 8'h22);
    test_overrun(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    test_ferr_glitch();
    test_rx(8'($urandom_range(0, 255)));
    test_drop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
